// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution frame sequencer.
package conv_pkg;

    typedef logic [2:0][2:0][7:0] kernel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int CFG_SHIFT_ADDR = 9;
    localparam int KERNEL_TAPS    = 9;

    // Length of one pass: every input pixel, one row of lag, then the pipeline drain.
    function automatic int calc_run_len(int sw_cnt, int rd_cnt, int pipe_lat);
        return sw_cnt * rd_cnt + rd_cnt + pipe_lat;
    endfunction

endpackage

// File: rtl/conv_cfg_regs.sv
// Kernel/shift configuration: host-written shadow copy plus an active copy
// that is only refreshed by the load strobe at frame start.
module conv_cfg_regs
    import conv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_wr_i,
    input  logic [3:0]       cfg_addr_i,
    input  logic [7:0]       cfg_data_i,
    input  logic             load_i,
    output logic [2:0][2:0][7:0] coeffs_o,
    output logic [7:0]       shift_o
);

    kernel_t    shadow_k_q;
    logic [7:0] shadow_sh_q;
    kernel_t    active_k_q;
    logic [7:0] active_sh_q;

    // Shadow write decode and active load; a write in the load cycle lands in
    // the shadow only, so the active copy takes the pre-write value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_k_q  <= '0;
            shadow_sh_q <= '0;
            active_k_q  <= '0;
            active_sh_q <= '0;
        end else begin
            if (cfg_wr_i) begin
                if (cfg_addr_i == 4'(CFG_SHIFT_ADDR)) begin
                    shadow_sh_q <= cfg_data_i;
                end
                for (int i = 0; i < KERNEL_TAPS; i++) begin
                    if (cfg_addr_i == 4'(i)) begin
                        shadow_k_q[i / 3][i % 3] <= cfg_data_i;
                    end
                end
            end
            if (load_i) begin
                active_k_q  <= shadow_k_q;
                active_sh_q <= shadow_sh_q;
            end
        end
    end

    assign coeffs_o = active_k_q;
    assign shift_o  = active_sh_q;

endmodule

// File: rtl/conv_frame_sequencer.sv
// Sequences one 3x3 convolution pass per captured frame: streams the input
// bank in raster order and writes datapath output into a ping-pong bank.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16,
    parameter int PIPE_LAT    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_ready,
    input  logic        frame_bank,
    input  logic        cfg_wr,
    input  logic [3:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic [2:0][2:0][7:0] coeffs,
    output logic [7:0]  shift,
    output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] in_rd_addr,
    output logic        in_rd_bank,
    output logic        out_wr_en,
    output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] out_wr_addr,
    output logic        out_wr_bank,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam int N       = SW_WIRE_CNT * RD_WIRE_CNT;
    localparam int AW      = $clog2(N);
    localparam int RUN_LEN = calc_run_len(SW_WIRE_CNT, RD_WIRE_CNT, PIPE_LAT);
    localparam int LAG     = RD_WIRE_CNT + PIPE_LAT;
    localparam int TW      = $clog2(RUN_LEN);

    seq_state_t    state_q;
    logic [TW-1:0] t_q;
    logic          pend_q;
    logic          pend_bank_q;
    logic          in_rd_bank_q;
    logic          out_wr_bank_q;
    logic          busy_q;
    logic          done_q;
    logic          overrun_q;
    logic [15:0]   frame_cnt_q;
    logic          start;

    // A pass starts from IDLE on a fresh frame or one queued during the last pass.
    assign start = (state_q == IDLE) && (frame_ready || pend_q);

    conv_cfg_regs u_cfg (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_wr_i   (cfg_wr),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_data),
        .load_i     (start),
        .coeffs_o   (coeffs),
        .shift_o    (shift)
    );

    // Pass FSM with cycle counter, pending-frame capture and completion bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            t_q           <= '0;
            pend_q        <= 1'b0;
            pend_bank_q   <= 1'b0;
            in_rd_bank_q  <= 1'b0;
            out_wr_bank_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        t_q          <= '0;
                        pend_q       <= 1'b0;
                        in_rd_bank_q <= frame_ready ? frame_bank : pend_bank_q;
                    end
                end
                RUN: begin
                    if (t_q == TW'(RUN_LEN - 1)) begin
                        state_q       <= DONE;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        frame_cnt_q   <= frame_cnt_q + 16'd1;
                        out_wr_bank_q <= ~out_wr_bank_q;
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // Frames arriving while busy queue one deep; the first one wins.
            if (frame_ready && state_q != IDLE) begin
                if (pend_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    pend_q      <= 1'b1;
                    pend_bank_q <= frame_bank;
                end
            end
        end
    end

    // Read address sweeps the frame, then parks on the last pixel while the pipe drains.
    assign in_rd_addr  = (state_q == RUN) ? ((t_q < TW'(N)) ? AW'(t_q) : AW'(N - 1)) : '0;
    assign out_wr_en   = (state_q == RUN) && (t_q >= TW'(LAG));
    assign out_wr_addr = out_wr_en ? AW'(t_q - TW'(LAG)) : '0;
    assign in_rd_bank  = in_rd_bank_q;
    assign out_wr_bank = out_wr_bank_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench: stimulus queues the expected per-pass result, a monitor
// tracks each pass and checks it when the done pulse appears.
module tb_conv_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_ready = 1'b0;
    logic        frame_bank = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic [2:0][2:0][7:0] coeffs;
    logic [7:0]  shift;
    logic [7:0]  in_rd_addr;
    logic        in_rd_bank;
    logic        out_wr_en;
    logic [7:0]  out_wr_addr;
    logic        out_wr_bank;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [15:0] frame_cnt;

    conv_frame_sequencer dut (
        .clk(clk), .rst(rst), .frame_ready(frame_ready), .frame_bank(frame_bank),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .coeffs(coeffs), .shift(shift), .in_rd_addr(in_rd_addr), .in_rd_bank(in_rd_bank),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_bank(out_wr_bank),
        .busy(busy), .done(done), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bank;
        logic [7:0] c11;
        logic [7:0] sh;
        int         cnt;
        bit         chained;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic bank, input logic [7:0] c11, input logic [7:0] sh,
                            input int cnt, input bit chained);
        exp_t e;
        e.bank = bank; e.c11 = c11; e.sh = sh; e.cnt = cnt; e.chained = chained;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input logic bank);
        frame_ready = 1'b1;
        frame_bank  = bank;
        tick(1);
        frame_ready = 1'b0;
        frame_bank  = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        tick(1);
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (done_seen < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("pass_complete", done_seen, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_addr"}, in_rd_addr, 0);
        chk({tag, "_rd_bank"}, in_rd_bank, 0);
        chk({tag, "_wr_en"}, out_wr_en, 0);
        chk({tag, "_wr_addr"}, out_wr_addr, 0);
        chk({tag, "_wr_bank"}, out_wr_bank, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_shift"}, shift, 0);
        chk({tag, "_coeffs_nz"}, int'(coeffs != '0), 0);
    endtask

    // Monitor: follows each pass and scores it against the queued expectation.
    initial begin
        bit   in_pass = 0;
        int   cyc = 0, gcyc = 0, last_done = -100;
        int   rd_err = 0, wr_err = 0, cfg_err = 0, wr_cnt = 0, first_wr = -1, last_wr = -1;
        int   exp_wr = 0;
        logic sb = 0;
        logic [7:0] sc = 0, ss = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pass = 0;
            end else begin
                gcyc++;
                if (busy && done) chk("busy_done_overlap", 1, 0);
                if (busy) begin
                    if (!in_pass) begin
                        in_pass = 1; cyc = 0; rd_err = 0; wr_err = 0; cfg_err = 0;
                        wr_cnt = 0; first_wr = -1; last_wr = -1; exp_wr = 0;
                        sb = in_rd_bank; sc = coeffs[1][1]; ss = shift;
                        if (exp_q.size() > 0 && exp_q[0].chained)
                            chk("idle_gap", gcyc - last_done, 2);
                    end
                    if (int'(in_rd_addr) != ((cyc < 256) ? cyc : 255)) rd_err++;
                    if (coeffs[1][1] != sc || shift != ss || in_rd_bank != sb) cfg_err++;
                    if (out_wr_en) begin
                        if (int'(out_wr_addr) != exp_wr) wr_err++;
                        if (first_wr < 0) first_wr = cyc;
                        last_wr = cyc;
                        exp_wr++;
                        wr_cnt++;
                    end
                    cyc++;
                end
                if (done) begin
                    done_seen++;
                    last_done = gcyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pass", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_len", cyc, 277);
                        chk("rd_bank", sb, e.bank);
                        chk("rd_addr_errs", rd_err, 0);
                        chk("wr_addr_errs", wr_err, 0);
                        chk("cfg_stable_errs", cfg_err, 0);
                        chk("wr_count", wr_cnt, 256);
                        chk("first_wr_t", first_wr, 21);
                        chk("last_wr_t", last_wr, 276);
                        chk("coeff11", sc, e.c11);
                        chk("shift", ss, e.sh);
                        chk("frame_cnt", frame_cnt, e.cnt);
                        chk("wr_bank", out_wr_bank, e.cnt % 2);
                    end
                    in_pass = 0;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(2);
        chk("idle_busy", busy, 0);

        // Single frame on bank 1 with default config.
        push_exp(1'b1, 8'h00, 8'h00, 1, 0);
        pulse_frame(1'b1);
        wait_dones(1);

        // Config timing: active copy only changes at frame start.
        cfg_write(4'd4, 8'h10);
        cfg_write(4'd9, 8'd4);
        chk("active_unchanged_idle", coeffs[1][1], 8'h00);
        push_exp(1'b0, 8'h10, 8'd4, 2, 0);
        pulse_frame(1'b0);
        tick(30);
        cfg_write(4'd4, 8'hF0);
        chk("active_held_midrun", coeffs[1][1], 8'h10);
        wait_dones(2);
        push_exp(1'b1, 8'hF0, 8'd4, 3, 0);
        pulse_frame(1'b1);
        wait_dones(3);

        // Pending frame queued at t=50.
        push_exp(1'b0, 8'hF0, 8'd4, 4, 0);
        push_exp(1'b1, 8'hF0, 8'd4, 5, 1);
        pulse_frame(1'b0);
        tick(49);
        pulse_frame(1'b1);
        wait_dones(5);
        chk("overrun_after_pending", overrun, 0);

        // Overrun: third pulse dropped, first pending bank kept.
        push_exp(1'b0, 8'hF0, 8'd4, 6, 0);
        push_exp(1'b1, 8'hF0, 8'd4, 7, 1);
        pulse_frame(1'b0);
        tick(10);
        pulse_frame(1'b1);
        tick(10);
        pulse_frame(1'b0);
        chk("overrun_set", overrun, 1);
        wait_dones(7);
        tick(300);
        chk("no_third_pass", done_seen, 7);
        chk("exp_queue_empty", exp_q.size(), 0);

        // Shift write coinciding with the start cycle applies to the next pass.
        push_exp(1'b0, 8'hF0, 8'd4, 8, 0);
        frame_ready = 1'b1; frame_bank = 1'b0;
        cfg_wr = 1'b1; cfg_addr = 4'd9; cfg_data = 8'd7;
        tick(1);
        frame_ready = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
        wait_dones(8);
        push_exp(1'b1, 8'hF0, 8'd7, 9, 0);
        pulse_frame(1'b1);
        wait_dones(9);

        // Asynchronous reset at t=100 abandons the pass.
        pulse_frame(1'b0);
        tick(100);
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrun_rst");
        tick(2);
        rst = 1'b0;
        tick(300);
        chk("no_done_after_rst", done_seen, 9);
        push_exp(1'b1, 8'h00, 8'h00, 1, 0);
        pulse_frame(1'b1);
        wait_dones(10);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
